// File: rtl/mha_mat_pkg.sv
// Shared types for moving 16x128 int8 matrices to and from BRAM.
// One BRAM word carries four consecutive matrix rows, row-major inside.
package mha_mat_pkg;

  localparam int MAT_ROWS  = 16;
  localparam int MAT_COLS  = 128;
  localparam int MAT_DW    = 8;
  localparam int MAT_RPW   = 4;
  localparam int BRAM_AW   = 8;
  localparam int BRAM_DW   = MAT_RPW * MAT_COLS * MAT_DW;
  localparam int SEL_W     = 6;
  localparam int MAT_WORDS = MAT_ROWS / MAT_RPW;

  typedef logic [MAT_DW-1:0] elem_t;
  typedef elem_t [0:MAT_ROWS-1][0:MAT_COLS-1] mat_t;
  typedef elem_t [0:MAT_RPW-1][0:MAT_COLS-1] slice_t;
  typedef logic [BRAM_DW-1:0] bram_word_t;

  typedef enum logic {
    S_IDLE,
    S_WRITE
  } state_t;

  // Row x, column y of the slice lands at element index x*COLS+y.
  function automatic bram_word_t pack_slice(input slice_t s);
    bram_word_t w;
    w = '0;
    for (int x = 0; x < MAT_RPW; x++)
      for (int y = 0; y < MAT_COLS; y++)
        w[(x*MAT_COLS+y)*MAT_DW +: MAT_DW] = s[x][y];
    return w;
  endfunction

  function automatic slice_t unpack_word(input bram_word_t w);
    slice_t s;
    for (int x = 0; x < MAT_RPW; x++)
      for (int y = 0; y < MAT_COLS; y++)
        s[x][y] = w[(x*MAT_COLS+y)*MAT_DW +: MAT_DW];
    return s;
  endfunction

endpackage

// File: rtl/mat_word_pack.sv
// Selects the four rows belonging to one BRAM word and packs them.
// Purely combinational; the caller registers the result.
module mat_word_pack
  import mha_mat_pkg::*;
(
  input  mat_t       i_mat,
  input  logic [1:0] i_word,
  output bram_word_t o_word
);

  slice_t w_slice;

  always_comb begin
    w_slice = '0;
    for (int x = 0; x < MAT_RPW; x++)
      w_slice[x] = i_mat[{i_word, 2'(x)}];
  end

  assign o_word = pack_slice(w_slice);

endmodule

// File: rtl/put_mat_to_bram.sv
// Captures a 16x128 int8 matrix on a start pulse and writes it as
// four packed 4096-bit words to BRAM slot I_SEL (addresses I_SEL*4+w).
module put_mat_to_bram
  import mha_mat_pkg::*;
(
  input  logic             I_CLK,
  input  logic             I_RST,
  input  logic             I_VLD_PULSE,
  input  logic [SEL_W-1:0] I_SEL,
  input  mat_t             I_MAT,
  output logic             O_READY,
  output logic             O_WEA,
  output logic [BRAM_AW-1:0] O_ADDRA,
  output bram_word_t       O_DINA,
  output logic             O_DONE
);

  state_t             r_state;
  state_t             w_state_nxt;
  mat_t               r_buf;
  logic [SEL_W-1:0]   r_base;
  logic [2:0]         r_beat;
  logic               r_ready;
  logic               r_wea;
  logic [BRAM_AW-1:0] r_addra;
  bram_word_t         r_dina;
  logic               r_done;

  logic       w_accept;
  logic       w_last;
  logic       w_beat_go;
  mat_t       w_src;
  logic [1:0] w_word;
  bram_word_t w_pack;

  assign w_accept  = (r_state == S_IDLE) && I_VLD_PULSE;
  assign w_last    = (r_state == S_WRITE) && (r_beat == 3'd4);
  assign w_beat_go = (r_state == S_WRITE) && !w_last;

  // Word 0 is packed straight from the input so it leaves on the accept edge.
  assign w_src  = w_accept ? I_MAT : r_buf;
  assign w_word = w_accept ? 2'd0 : r_beat[1:0];

  mat_word_pack u_pack (
    .i_mat  (w_src),
    .i_word (w_word),
    .o_word (w_pack)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (I_VLD_PULSE) w_state_nxt = S_WRITE;
      S_WRITE: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      r_buf   <= '0;
      r_base  <= '0;
      r_beat  <= '0;
      r_ready <= 1'b1;
      r_wea   <= 1'b0;
      r_addra <= '0;
      r_dina  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done  <= w_last;
      r_ready <= (w_state_nxt == S_IDLE);
      r_wea   <= w_accept || w_beat_go;
      if (w_accept) begin
        r_buf   <= I_MAT;
        r_base  <= I_SEL;
        r_beat  <= 3'd1;
        r_addra <= {I_SEL, 2'd0};
        r_dina  <= w_pack;
      end else if (w_beat_go) begin
        r_addra <= {r_base, r_beat[1:0]};
        r_dina  <= w_pack;
        r_beat  <= r_beat + 3'd1;
      end
    end
  end

  assign O_READY = r_ready;
  assign O_WEA   = r_wea;
  assign O_ADDRA = r_addra;
  assign O_DINA  = r_dina;
  assign O_DONE  = r_done;

endmodule
